// File: rtl/load_tag_buffer_if.sv
// Load-issue, cache-response and writeback signals shared between the load unit,
// the data cache and the load tag buffer.
interface load_tag_buffer_if #(
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 2,
  parameter int TAG_BITS      = 1
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [TRANS_ID_BITS-1:0] req_trans_id_i;
  logic [OFF_W-1:0]         req_offset_i;
  logic [1:0]               req_size_i;
  logic                     req_signed_i;
  logic [TAG_BITS-1:0]      req_tag_o;

  logic                     rsp_valid_i;
  logic [TAG_BITS-1:0]      rsp_tag_i;
  logic [XLEN-1:0]          rsp_data_i;

  logic                     result_valid_o;
  logic [TRANS_ID_BITS-1:0] result_trans_id_o;
  logic [XLEN-1:0]          result_o;

  modport slave (
    input  req_valid_i, req_trans_id_i, req_offset_i, req_size_i, req_signed_i,
    input  rsp_valid_i, rsp_tag_i, rsp_data_i,
    output req_ready_o, req_tag_o,
    output result_valid_o, result_trans_id_o, result_o
  );

  modport master (
    output req_valid_i, req_trans_id_i, req_offset_i, req_size_i, req_signed_i,
    output rsp_valid_i, rsp_tag_i, rsp_data_i,
    input  req_ready_o, req_tag_o,
    input  result_valid_o, result_trans_id_o, result_o
  );
endinterface

// File: rtl/load_tag_buffer.sv
// Tracks in-flight loads by cache tag, matches out-of-order responses to their
// metadata and produces a registered, aligned and extended writeback result.
module load_tag_buffer #(
  parameter int NR_ENTRIES    = 2,
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 2,
  parameter int TAG_BITS      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  load_tag_buffer_if.slave   bus,
  output logic [TAG_BITS:0]  count_o,
  output logic               empty_o
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic [NR_ENTRIES-1:0]    valid_q, valid_d;
  logic [NR_ENTRIES-1:0]    killed_q, killed_d;
  logic [TRANS_ID_BITS-1:0] tid_q  [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] tid_d  [NR_ENTRIES];
  logic [OFF_W-1:0]         off_q  [NR_ENTRIES];
  logic [OFF_W-1:0]         off_d  [NR_ENTRIES];
  logic [1:0]               size_q [NR_ENTRIES];
  logic [1:0]               size_d [NR_ENTRIES];
  logic                     sgn_q  [NR_ENTRIES];
  logic                     sgn_d  [NR_ENTRIES];

  logic                     result_valid_q, result_valid_d;
  logic [TRANS_ID_BITS-1:0] result_tid_q, result_tid_d;
  logic [XLEN-1:0]          result_q, result_d;

  logic                     free_found;
  logic [TAG_BITS-1:0]      free_idx;
  logic [TAG_BITS:0]        count_c;
  logic                     req_ready;
  logic                     alloc;
  logic                     rsp_live, rsp_hit;
  logic                     sel_killed;
  logic [TRANS_ID_BITS-1:0] sel_tid;
  logic [OFF_W-1:0]         sel_off;
  logic [1:0]               sel_size;
  logic                     sel_sgn;

  // Shift the addressed field down, keep 8/16/32/64 bits and fill the rest.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [OFF_W-1:0] off,
                                             input logic [1:0]       size,
                                             input logic             sgn);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] res;
    logic            msb;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    begin mask = ~({XLEN{1'b1}} << 8);  msb = sh[7];      end
      2'd1:    begin mask = ~({XLEN{1'b1}} << 16); msb = sh[15];     end
      2'd2:    begin mask = ~({XLEN{1'b1}} << 32); msb = sh[31];     end
      default: begin mask = {XLEN{1'b1}};          msb = sh[XLEN-1]; end
    endcase
    res = sh & mask;
    if (sgn && msb) res = res | ~mask;
    return res;
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    count_c    = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = TAG_BITS'(i);
      end
      count_c = count_c + (TAG_BITS+1)'(valid_q[i]);
    end
  end

  assign req_ready = free_found && !flush_i;
  assign alloc     = bus.req_valid_i && req_ready;

  always_comb begin
    rsp_live   = 1'b0;
    sel_killed = 1'b0;
    sel_tid    = '0;
    sel_off    = '0;
    sel_size   = '0;
    sel_sgn    = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (bus.rsp_tag_i == TAG_BITS'(i)) begin
        rsp_live   = valid_q[i];
        sel_killed = killed_q[i];
        sel_tid    = tid_q[i];
        sel_off    = off_q[i];
        sel_size   = size_q[i];
        sel_sgn    = sgn_q[i];
      end
    end
  end

  assign rsp_hit = bus.rsp_valid_i && rsp_live;

  // A flush kills every live entry; the response path still frees them later.
  always_comb begin
    valid_d  = valid_q;
    killed_d = flush_i ? (killed_q | valid_q) : killed_q;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      tid_d[i]  = tid_q[i];
      off_d[i]  = off_q[i];
      size_d[i] = size_q[i];
      sgn_d[i]  = sgn_q[i];
      if (rsp_hit && bus.rsp_tag_i == TAG_BITS'(i)) begin
        valid_d[i]  = 1'b0;
        killed_d[i] = 1'b0;
      end
      if (alloc && free_idx == TAG_BITS'(i)) begin
        valid_d[i]  = 1'b1;
        killed_d[i] = 1'b0;
        tid_d[i]    = bus.req_trans_id_i;
        off_d[i]    = bus.req_offset_i;
        size_d[i]   = bus.req_size_i;
        sgn_d[i]    = bus.req_signed_i;
      end
    end
  end

  always_comb begin
    result_valid_d = rsp_hit && !sel_killed && !flush_i;
    result_tid_d   = result_tid_q;
    result_d       = result_q;
    if (result_valid_d) begin
      result_tid_d = sel_tid;
      result_d     = extend(bus.rsp_data_i, sel_off, sel_size, sel_sgn);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q        <= '0;
      killed_q       <= '0;
      result_valid_q <= 1'b0;
      result_tid_q   <= '0;
      result_q       <= '0;
    end else begin
      valid_q        <= valid_d;
      killed_q       <= killed_d;
      result_valid_q <= result_valid_d;
      result_tid_q   <= result_tid_d;
      result_q       <= result_d;
    end
  end

  // Metadata is only meaningful while its valid bit is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    tid_q  <= tid_d;
    off_q  <= off_d;
    size_q <= size_d;
    sgn_q  <= sgn_d;
  end

  assign bus.req_ready_o       = req_ready;
  assign bus.req_tag_o         = free_idx;
  assign bus.result_valid_o    = result_valid_q;
  assign bus.result_trans_id_o = result_tid_q;
  assign bus.result_o          = result_q;
  assign count_o               = count_c;
  assign empty_o               = (count_c == '0);

  rsp_to_free_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.rsp_valid_i |-> rsp_live)
    else $error("response for tag %0d which has no outstanding load", bus.rsp_tag_i);

endmodule

// File: tb/tb_load_tag_buffer.sv
// Directed table-driven bench for load_tag_buffer (2 entries, 32-bit data),
// plus a hand-written asynchronous-reset sequence.
module tb_load_tag_buffer;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       flush_i = 1'b0;
  logic [1:0] count_o;
  logic       empty_o;

  int n_checks = 0;
  int n_fail   = 0;

  load_tag_buffer_if #(.XLEN(32), .TRANS_ID_BITS(2), .TAG_BITS(1)) bus ();

  load_tag_buffer #(.NR_ENTRIES(2), .XLEN(32), .TRANS_ID_BITS(2)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus     (bus),
    .count_o (count_o),
    .empty_o (empty_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        fl, rv;
    logic [1:0]  tid, off, sz;
    logic        sg, sv, stag;
    logic [31:0] sdata;
    logic        e_rdy, e_tag;
    logic [1:0]  e_cnt;
    logic        e_rv;
    logic [1:0]  e_tid;
    logic [31:0] e_res;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic fl, input logic rv, input logic [1:0] tid,
                     input logic [1:0] off, input logic [1:0] sz, input logic sg,
                     input logic sv, input logic stag, input logic [31:0] sdata,
                     input logic e_rdy, input logic e_tag, input logic [1:0] e_cnt,
                     input logic e_rv, input logic [1:0] e_tid, input logic [31:0] e_res);
    vec_t v;
    v.fl = fl; v.rv = rv; v.tid = tid; v.off = off; v.sz = sz; v.sg = sg;
    v.sv = sv; v.stag = stag; v.sdata = sdata;
    v.e_rdy = e_rdy; v.e_tag = e_tag; v.e_cnt = e_cnt;
    v.e_rv = e_rv; v.e_tid = e_tid; v.e_res = e_res;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    flush_i            = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_trans_id_i = '0;
    bus.req_offset_i   = '0;
    bus.req_size_i     = '0;
    bus.req_signed_i   = 1'b0;
    bus.rsp_valid_i    = 1'b0;
    bus.rsp_tag_i      = '0;
    bus.rsp_data_i     = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " count"},     64'(count_o),               64'd0);
    chk({tag, " empty"},     64'(empty_o),               64'd1);
    chk({tag, " ready"},     64'(bus.req_ready_o),       64'd1);
    chk({tag, " res_valid"}, 64'(bus.result_valid_o),    64'd0);
    chk({tag, " res_tid"},   64'(bus.result_trans_id_o), 64'd0);
    chk({tag, " result"},    64'(bus.result_o),          64'd0);
  endtask

  initial begin
    drive_idle();
    // fl rv tid off sz sg | sv stag sdata | rdy tag cnt | rv tid result
    add(0,1,1,2,1,0, 0,0,32'h0,          1,0,0, 0,0,32'h0);
    add(0,1,3,0,0,1, 0,0,32'h0,          1,1,1, 0,0,32'h0);
    add(0,1,2,0,2,0, 0,0,32'h0,          0,0,2, 0,0,32'h0);
    add(0,0,0,0,0,0, 1,1,32'h8000_00F0,  0,0,2, 0,0,32'h0);
    add(0,0,0,0,0,0, 1,0,32'h1234_5678,  1,1,1, 1,3,32'hFFFF_FFF0);
    add(0,0,0,0,0,0, 0,0,32'h0,          1,0,0, 1,1,32'h0000_1234);
    add(0,0,0,0,0,0, 0,0,32'h0,          1,0,0, 0,0,32'h0);
    add(0,1,0,0,2,0, 0,0,32'h0,          1,0,0, 0,0,32'h0);
    add(0,1,1,0,2,0, 0,0,32'h0,          1,1,1, 0,0,32'h0);
    add(1,1,2,0,2,0, 0,0,32'h0,          0,0,2, 0,0,32'h0);
    add(0,0,0,0,0,0, 1,0,32'hAAAA_AAAA,  0,0,2, 0,0,32'h0);
    add(0,0,0,0,0,0, 1,1,32'h5555_5555,  1,0,1, 0,0,32'h0);
    add(0,0,0,0,0,0, 0,0,32'h0,          1,0,0, 0,0,32'h0);
    add(1,1,2,0,2,0, 0,0,32'h0,          0,0,0, 0,0,32'h0);
    add(0,0,0,0,0,0, 0,0,32'h0,          1,0,0, 0,0,32'h0);
    add(0,1,2,0,2,0, 0,0,32'h0,          1,0,0, 0,0,32'h0);
    add(0,1,3,1,0,0, 0,0,32'h0,          1,1,1, 0,0,32'h0);
    add(0,1,1,3,0,1, 1,0,32'h1122_3344,  0,0,2, 0,0,32'h0);
    add(0,1,1,3,0,1, 0,0,32'h0,          1,0,1, 1,2,32'h1122_3344);
    add(0,0,0,0,0,0, 1,0,32'h7F00_0000,  0,0,2, 0,0,32'h0);
    add(0,0,0,0,0,0, 1,1,32'h0000_AB00,  1,0,1, 1,1,32'h0000_007F);
    add(0,1,0,3,0,1, 0,0,32'h0,          1,0,0, 1,3,32'h0000_00AB);
    add(0,0,0,0,0,0, 1,0,32'h8000_0000,  1,1,1, 0,0,32'h0);
    add(0,0,0,0,0,0, 0,0,32'h0,          1,0,0, 1,0,32'hFFFF_FF80);
    add(0,1,2,0,2,0, 0,0,32'h0,          1,0,0, 0,0,32'h0);
    add(1,0,0,0,0,0, 1,0,32'hDEAD_BEEF,  0,0,1, 0,0,32'h0);
    add(0,0,0,0,0,0, 0,0,32'h0,          1,0,0, 0,0,32'h0);

    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check_reset_state("reset");
    @(negedge clk_i) rst_ni = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk_i);
      #1;
      flush_i            = vq[i].fl;
      bus.req_valid_i    = vq[i].rv;
      bus.req_trans_id_i = vq[i].tid;
      bus.req_offset_i   = vq[i].off;
      bus.req_size_i     = vq[i].sz;
      bus.req_signed_i   = vq[i].sg;
      bus.rsp_valid_i    = vq[i].sv;
      bus.rsp_tag_i      = vq[i].stag;
      bus.rsp_data_i     = vq[i].sdata;
      @(negedge clk_i);
      chk($sformatf("row%0d ready", i), 64'(bus.req_ready_o), 64'(vq[i].e_rdy));
      chk($sformatf("row%0d count", i), 64'(count_o), 64'(vq[i].e_cnt));
      chk($sformatf("row%0d empty", i), 64'(empty_o), 64'(vq[i].e_cnt == 2'd0));
      chk($sformatf("row%0d res_valid", i), 64'(bus.result_valid_o), 64'(vq[i].e_rv));
      if (vq[i].e_rdy)
        chk($sformatf("row%0d tag", i), 64'(bus.req_tag_o), 64'(vq[i].e_tag));
      if (vq[i].e_rv) begin
        chk($sformatf("row%0d res_tid", i), 64'(bus.result_trans_id_o), 64'(vq[i].e_tid));
        chk($sformatf("row%0d result", i), 64'(bus.result_o), 64'(vq[i].e_res));
      end
    end

    // Result fields keep the last delivered writeback while no result is valid.
    chk("hold res_tid", 64'(bus.result_trans_id_o), 64'd0);
    chk("hold result",  64'(bus.result_o), 64'hFFFF_FF80);

    // Asynchronous reset in the middle of traffic.
    @(posedge clk_i); #1;
    drive_idle();
    bus.req_valid_i = 1'b1; bus.req_trans_id_i = 2'd1; bus.req_size_i = 2'd2;
    @(posedge clk_i); #1;
    bus.req_trans_id_i = 2'd2;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    bus.rsp_valid_i = 1'b1; bus.rsp_tag_i = 1'b0; bus.rsp_data_i = 32'h0000_0042;
    @(posedge clk_i); #1;
    bus.rsp_valid_i = 1'b0;
    chk("pre-reset res_valid", 64'(bus.result_valid_o), 64'd1);
    chk("pre-reset result",    64'(bus.result_o), 64'h42);
    chk("pre-reset count",     64'(count_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1 check_reset_state("async reset");
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);
    check_reset_state("after release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
